// File: rtl/avalon_burst_slave.sv
// avalon_burst_slave: Avalon-MM burst slave front-end for the classifier accelerator.
// Burst writes load the pixel and weight SRAMs. Burst reads return result words and status.
// Every beat is decoded by address and gets an OKAY, SLAVEERROR or DECODEERROR response.
// Optional feature macro: AVALON_WRITE_RESPONSE_EN. When it is defined, the slave adds a WR_RESP
// state and drives writeresponsevalid. When it is undefined, writeresponsevalid is tied to 0.
module avalon_burst_slave #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 11,
    parameter int BURST_W   = 10,
    parameter int STORE_W   = 16,
    parameter int PIX_BASE  = 0,
    parameter int PIX_DEPTH = 784,
    parameter int WGT_BASE  = 1024,
    parameter int WGT_DEPTH = 784,
    parameter int RES_BASE  = 1920,
    parameter int RES_DEPTH = 16,
    parameter int STAT_ADDR = 1984,
    parameter int OA_W      = $clog2(RES_DEPTH)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               write,
    input  logic               read,
    input  logic               beginbursttransfer,
    input  logic [BURST_W-1:0] burstcount,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  writedata,
    output logic [DATA_W-1:0]  readdata,
    output logic               readdatavalid,
    output logic               waitrequest,
    output logic               writeresponsevalid,
    output logic [1:0]         response,
    input  logic [DATA_W-1:0]  result_output,
    input  logic               done_calc,
    output logic [OA_W-1:0]    output_address,
    output logic [ADDR_W-1:0]  pixel_address,
    output logic [ADDR_W-1:0]  weight_address,
    output logic               w_enable_pixels,
    output logic               w_enable_weights,
    output logic [STORE_W-1:0] store_data
);

    // One spare bit so burst addresses past the top of the map never wrap.
    localparam int AW1 = ADDR_W + 1;

    localparam logic [1:0] RSP_OKAY   = 2'b00;
    localparam logic [1:0] RSP_SLVERR = 2'b10;
    localparam logic [1:0] RSP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, WR_RESP} state_t;
    typedef enum logic [2:0] {RG_NONE, RG_PIX, RG_WGT, RG_RES, RG_STAT} region_t;

`ifdef AVALON_WRITE_RESPONSE_EN
    localparam state_t WR_DONE = WR_RESP;
`else
    localparam state_t WR_DONE = IDLE;
`endif

    function automatic region_t decode(input logic [AW1-1:0] a);
        int ai;
        ai = int'(a);
        if (ai >= PIX_BASE && ai < PIX_BASE + PIX_DEPTH)      return RG_PIX;
        else if (ai >= WGT_BASE && ai < WGT_BASE + WGT_DEPTH) return RG_WGT;
        else if (ai >= RES_BASE && ai < RES_BASE + RES_DEPTH) return RG_RES;
        else if (ai == STAT_ADDR)                             return RG_STAT;
        else                                                  return RG_NONE;
    endfunction

    function automatic logic [1:0] wr_rsp(input region_t rg);
        case (rg)
            RG_PIX, RG_WGT:  return RSP_OKAY;
            RG_RES, RG_STAT: return RSP_SLVERR;
            default:         return RSP_DECERR;
        endcase
    endfunction

    function automatic logic [1:0] rd_rsp(input region_t rg);
        case (rg)
            RG_RES, RG_STAT: return RSP_OKAY;
            RG_PIX, RG_WGT:  return RSP_SLVERR;
            default:         return RSP_DECERR;
        endcase
    endfunction

    // The encodings are ordered so that a numeric max gives the worst response.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t             state_q, state_d;
    logic [BURST_W-1:0] wr_left_q, wr_left_d;
    logic [BURST_W-1:0] rd_left_q, rd_left_d;
    logic [AW1-1:0]     beat_addr_q, beat_addr_d;
    logic [1:0]         wr_err_q, wr_err_d;

    logic               w_enable_pixels_q, w_enable_weights_q;
    logic [ADDR_W-1:0]  pixel_address_q, weight_address_q;
    logic [STORE_W-1:0] store_data_q;

    logic               vld_p1_q;
    region_t            rg_p1_q;
    logic [OA_W-1:0]    output_address_q;
    logic               vld_p2_q;
    logic [DATA_W-1:0]  readdata_p2_q;
    logic [1:0]         rsp_p2_q;

    logic [BURST_W-1:0] blen;
    logic [AW1-1:0]     cur_addr;
    region_t            cur_rg;
    logic               wr_beat, rd_issue;
    logic [DATA_W-1:0]  rd_data_c;
    logic               unused_wdata;

    assign unused_wdata = ^writedata[DATA_W-1:STORE_W];

    // The first beat uses the bus address. Later beats use the internal beat counter.
    assign cur_addr = (state_q == IDLE) ? {1'b0, address} : beat_addr_q;
    assign cur_rg   = decode(cur_addr);
    assign blen     = (beginbursttransfer && burstcount != '0) ? burstcount : BURST_W'(1);

    // FSM state and burst bookkeeping registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            wr_left_q   <= '0;
            rd_left_q   <= '0;
            beat_addr_q <= '0;
            wr_err_q    <= RSP_OKAY;
        end else begin
            state_q     <= state_d;
            wr_left_q   <= wr_left_d;
            rd_left_q   <= rd_left_d;
            beat_addr_q <= beat_addr_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Next state logic, command acceptance and beat issue.
    always_comb begin
        state_d     = state_q;
        wr_left_d   = wr_left_q;
        rd_left_d   = rd_left_q;
        beat_addr_d = beat_addr_q;
        wr_err_d    = wr_err_q;
        wr_beat     = 1'b0;
        rd_issue    = 1'b0;
        case (state_q)
            IDLE: begin
                beat_addr_d = {1'b0, address} + AW1'(1);
                if (write) begin
                    wr_beat   = 1'b1;
                    wr_err_d  = wr_rsp(cur_rg);
                    wr_left_d = blen - BURST_W'(1);
                    state_d   = (blen == BURST_W'(1)) ? WR_DONE : WR_BURST;
                end else if (read) begin
                    rd_issue  = 1'b1;
                    rd_left_d = blen - BURST_W'(1);
                    state_d   = RD_BURST;
                end
            end
            WR_BURST: begin
                if (write) begin
                    wr_beat     = 1'b1;
                    wr_err_d    = worst(wr_err_q, wr_rsp(cur_rg));
                    beat_addr_d = beat_addr_q + AW1'(1);
                    wr_left_d   = wr_left_q - BURST_W'(1);
                    if (wr_left_q == BURST_W'(1)) state_d = WR_DONE;
                end
            end
            RD_BURST: begin
                if (rd_left_q != '0) begin
                    rd_issue    = 1'b1;
                    beat_addr_d = beat_addr_q + AW1'(1);
                    rd_left_d   = rd_left_q - BURST_W'(1);
                end else if (!vld_p1_q) begin
                    state_d = IDLE;
                end
            end
            WR_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered memory write strobes, region-relative addresses and store data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_enable_pixels_q  <= 1'b0;
            w_enable_weights_q <= 1'b0;
            pixel_address_q    <= '0;
            weight_address_q   <= '0;
            store_data_q       <= '0;
        end else begin
            w_enable_pixels_q  <= wr_beat && (cur_rg == RG_PIX);
            w_enable_weights_q <= wr_beat && (cur_rg == RG_WGT);
            if (wr_beat && cur_rg == RG_PIX)
                pixel_address_q <= ADDR_W'(cur_addr - AW1'(PIX_BASE));
            if (wr_beat && cur_rg == RG_WGT)
                weight_address_q <= ADDR_W'(cur_addr - AW1'(WGT_BASE));
            if (wr_beat && (cur_rg == RG_PIX || cur_rg == RG_WGT))
                store_data_q <= writedata[STORE_W-1:0];
        end
    end

    // Read stage 1: present the result buffer index the cycle after issue.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p1_q         <= 1'b0;
            rg_p1_q          <= RG_NONE;
            output_address_q <= '0;
        end else begin
            vld_p1_q <= rd_issue;
            rg_p1_q  <= cur_rg;
            if (rd_issue && cur_rg == RG_RES)
                output_address_q <= OA_W'(cur_addr - AW1'(RES_BASE));
        end
    end

    // Select the read data for the beat in stage 1.
    always_comb begin
        rd_data_c = '0;
        case (rg_p1_q)
            RG_RES:  rd_data_c = result_output;
            RG_STAT: rd_data_c[0] = done_calc;
            default: rd_data_c = '0;
        endcase
    end

    // Read stage 2: register the beat. Data and response are forced to 0 when no beat is valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p2_q      <= 1'b0;
            readdata_p2_q <= '0;
            rsp_p2_q      <= RSP_OKAY;
        end else begin
            vld_p2_q      <= vld_p1_q;
            readdata_p2_q <= vld_p1_q ? rd_data_c : '0;
            rsp_p2_q      <= vld_p1_q ? rd_rsp(rg_p1_q) : RSP_OKAY;
        end
    end

    assign waitrequest      = !n_rst || (state_q == RD_BURST) || (state_q == WR_RESP);
    assign readdata         = readdata_p2_q;
    assign readdatavalid    = vld_p2_q;
    assign output_address   = output_address_q;
    assign pixel_address    = pixel_address_q;
    assign weight_address   = weight_address_q;
    assign w_enable_pixels  = w_enable_pixels_q;
    assign w_enable_weights = w_enable_weights_q;
    assign store_data       = store_data_q;

`ifdef AVALON_WRITE_RESPONSE_EN
    assign writeresponsevalid = (state_q == WR_RESP);
    assign response           = (state_q == WR_RESP) ? wr_err_q : rsp_p2_q;
`else
    assign writeresponsevalid = 1'b0;
    assign response           = rsp_p2_q;
`endif

endmodule
